// File: rtl/gpr_wb_arb.sv
// gpr_wb_arb: write-back arbiter and late-result buffer for the GPR file write port.
//
// The in-order pipeline write-back always wins the port. Late results (multi-cycle load,
// multiply, divide) queue in a small circular FIFO and drain when the pipeline is idle.
// A newer pipeline write to the same register kills older buffered entries (WAW squash).
// Dead entries are popped without using the port.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   pipe_we_, pipe_addr,  pipeline write-back request (active-low), address, data
//   pipe_data
//   late_valid/ready,     late-result valid/ready handshake with address and data
//   late_addr, late_data
//   chk_addr_0/1          decode source registers to check
//   pending_0/1           a live buffered entry targets chk_addr_0/1
//   we_, wr_addr, wr_data register-file write port (we_ active-low)
module gpr_wb_arb #(
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pipe_we_,
   input  logic [ADDR_W-1:0] pipe_addr,
   input  logic [DATA_W-1:0] pipe_data,
   input  logic              late_valid,
   output logic              late_ready,
   input  logic [ADDR_W-1:0] late_addr,
   input  logic [DATA_W-1:0] late_data,
   input  logic [ADDR_W-1:0] chk_addr_0,
   input  logic [ADDR_W-1:0] chk_addr_1,
   output logic              pending_0,
   output logic              pending_1,
   output logic              we_,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;

   logic [DEPTH-1:0]  live_q;
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0]   count_q;

   logic full, empty, head_live, push, pop, pipe_wr;

   always_comb begin
      full       = (count_q == CntW'(DEPTH));
      empty      = (count_q == '0);
      head_live  = live_q[rd_ptr_q];
      pipe_wr    = reset && !pipe_we_;
      // Ready depends only on full so a pop never makes room for a same-cycle push.
      late_ready = reset && !full;
      push       = late_valid && late_ready;
      // Dead head pops regardless of the pipeline; live head only when the port is free.
      pop        = reset && !empty && (!head_live || pipe_we_);
   end

   // Write port select
   always_comb begin
      we_     = 1'b1;
      wr_addr = '0;
      wr_data = '0;
      if (pipe_wr) begin
         we_     = 1'b0;
         wr_addr = pipe_addr;
         wr_data = pipe_data;
      end else if (reset && !empty && head_live) begin
         we_     = 1'b0;
         wr_addr = addr_q[rd_ptr_q];
         wr_data = data_q[rd_ptr_q];
      end
   end

   // Hazard reporting covers stored live entries only; popped entries are cleared.
   always_comb begin
      pending_0 = 1'b0;
      pending_1 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (live_q[i] && addr_q[i] == chk_addr_0) pending_0 = 1'b1;
         if (live_q[i] && addr_q[i] == chk_addr_1) pending_1 = 1'b1;
      end
      pending_0 = pending_0 && reset;
      pending_1 = pending_1 && reset;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         live_q   <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (pipe_wr && live_q[i] && addr_q[i] == pipe_addr) live_q[i] <= 1'b0;
         end
         if (pop) begin
            live_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q         <= rd_ptr_q + 1'b1;
         end
         // wr_ptr never aliases a stored entry here since push implies not full.
         if (push) begin
            live_q[wr_ptr_q] <= !(pipe_wr && late_addr == pipe_addr);
            addr_q[wr_ptr_q] <= late_addr;
            data_q[wr_ptr_q] <= late_data;
            wr_ptr_q         <= wr_ptr_q + 1'b1;
         end
         if (push && !pop) count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
      end
   end

endmodule

// File: tb/tb_gpr_wb_arb.sv
module tb_gpr_wb_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic        pipe_we_;
   logic [4:0]  pipe_addr;
   logic [31:0] pipe_data;
   logic        late_valid;
   logic        late_ready;
   logic [4:0]  late_addr;
   logic [31:0] late_data;
   logic [4:0]  chk_addr_0, chk_addr_1;
   logic        pending_0, pending_1;
   logic        we_;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   gpr_wb_arb #(.DEPTH(2), .ADDR_W(5), .DATA_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .pipe_we_   (pipe_we_),
      .pipe_addr  (pipe_addr),
      .pipe_data  (pipe_data),
      .late_valid (late_valid),
      .late_ready (late_ready),
      .late_addr  (late_addr),
      .late_data  (late_data),
      .chk_addr_0 (chk_addr_0),
      .chk_addr_1 (chk_addr_1),
      .pending_0  (pending_0),
      .pending_1  (pending_1),
      .we_        (we_),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance past the next rising edge; inputs change 1 time unit after it.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; pipe_we_ = 1'b0; pipe_addr = 5'd3; pipe_data = 32'h1;
      late_valid = 1'b1; late_addr = 5'd4; late_data = 32'h2;
      chk_addr_0 = 5'd4; chk_addr_1 = 5'd0;
      cyc(); cyc();
      #1;
      chk("rst_we", we_, 1'b1);
      chk("rst_addr", wr_addr, 5'd0);
      chk("rst_data", wr_data, 32'h0);
      chk("rst_ready", late_ready, 1'b0);
      chk("rst_pend0", pending_0, 1'b0);

      cyc();
      reset = 1'b1; pipe_we_ = 1'b1; late_valid = 1'b0;
      #1;
      chk("rel_ready", late_ready, 1'b1);
      chk("rel_idle_we", we_, 1'b1);

      // Pipeline pass-through
      pipe_we_ = 1'b0; pipe_addr = 5'd3; pipe_data = 32'h1234_5678;
      #1;
      chk("pass_we", we_, 1'b0);
      chk("pass_addr", wr_addr, 5'd3);
      chk("pass_data", wr_data, 32'h1234_5678);

      // Buffered drain
      cyc();
      pipe_we_ = 1'b1; late_valid = 1'b1; late_addr = 5'd7; late_data = 32'hA5A5_A5A5;
      chk_addr_0 = 5'd7;
      #1;
      chk("drain_pre_we", we_, 1'b1);
      chk("drain_pre_pend", pending_0, 1'b0);
      cyc();
      late_valid = 1'b0;
      #1;
      chk("drain_we", we_, 1'b0);
      chk("drain_addr", wr_addr, 5'd7);
      chk("drain_data", wr_data, 32'hA5A5_A5A5);
      chk("drain_pend", pending_0, 1'b1);
      cyc();
      #1;
      chk("drain_post_we", we_, 1'b1);
      chk("drain_post_pend", pending_0, 1'b0);

      // Full and priority
      pipe_we_ = 1'b0; pipe_addr = 5'd9; pipe_data = 32'h99;
      late_valid = 1'b1; late_addr = 5'd1; late_data = 32'h101; chk_addr_0 = 5'd1;
      #1;
      chk("full_rdy0", late_ready, 1'b1);
      chk("full_port0", wr_addr, 5'd9);
      cyc();
      late_addr = 5'd2; late_data = 32'h202;
      #1;
      chk("full_rdy1", late_ready, 1'b1);
      chk("full_pend1", pending_0, 1'b1);
      cyc();
      late_valid = 1'b0;
      #1;
      chk("full_rdy2", late_ready, 1'b0);
      chk("full_port2_we", we_, 1'b0);
      chk("full_port2", wr_addr, 5'd9);
      pipe_we_ = 1'b1;
      #1;
      chk("full_d1_addr", wr_addr, 5'd1);
      chk("full_d1_data", wr_data, 32'h101);
      chk("full_d1_rdy", late_ready, 1'b0);
      cyc();
      #1;
      chk("full_d2_we", we_, 1'b0);
      chk("full_d2_addr", wr_addr, 5'd2);
      chk("full_d2_data", wr_data, 32'h202);
      chk("full_d2_rdy", late_ready, 1'b1);
      chk("full_d2_pend", pending_0, 1'b0);
      cyc();
      #1;
      chk("full_end_we", we_, 1'b1);

      // WAW squash of a waiting entry
      late_valid = 1'b1; late_addr = 5'd5; late_data = 32'h11; chk_addr_1 = 5'd5;
      pipe_we_ = 1'b0; pipe_addr = 5'd8; pipe_data = 32'h88;
      cyc();
      late_valid = 1'b0; pipe_addr = 5'd5; pipe_data = 32'h22;
      #1;
      chk("waw_pipe_addr", wr_addr, 5'd5);
      chk("waw_pipe_data", wr_data, 32'h22);
      chk("waw_pend_pre", pending_1, 1'b1);
      cyc();
      pipe_we_ = 1'b1;
      #1;
      chk("waw_dead_we", we_, 1'b1);
      chk("waw_pend_post", pending_1, 1'b0);
      cyc();
      #1;
      chk("waw_after_we", we_, 1'b1);
      chk("waw_after_rdy", late_ready, 1'b1);

      // Same-cycle push and pipeline write to the same register
      late_valid = 1'b1; late_addr = 5'd5; late_data = 32'h33;
      pipe_we_ = 1'b0; pipe_addr = 5'd5; pipe_data = 32'h44;
      #1;
      chk("same_data", wr_data, 32'h44);
      cyc();
      late_valid = 1'b0; pipe_we_ = 1'b1;
      #1;
      chk("same_we", we_, 1'b1);
      chk("same_pend", pending_1, 1'b0);
      cyc();
      #1;
      chk("same_after_we", we_, 1'b1);

      // Reset mid-operation discards two buffered entries
      late_valid = 1'b1; late_addr = 5'd10; late_data = 32'hA;
      pipe_we_ = 1'b0; pipe_addr = 5'd20; pipe_data = 32'h20; chk_addr_0 = 5'd10;
      cyc();
      late_addr = 5'd11; late_data = 32'hB;
      cyc();
      late_valid = 1'b0;
      #1;
      chk("mid_full", late_ready, 1'b0);
      chk("mid_pend", pending_0, 1'b1);
      reset = 1'b0; pipe_we_ = 1'b1;
      #1;
      chk("mid_rst_we", we_, 1'b1);
      chk("mid_rst_rdy", late_ready, 1'b0);
      chk("mid_rst_pend", pending_0, 1'b0);
      cyc();
      reset = 1'b1;
      #1;
      chk("mid_rel_we", we_, 1'b1);
      chk("mid_rel_rdy", late_ready, 1'b1);
      chk("mid_rel_pend", pending_0, 1'b0);
      cyc();
      #1;
      chk("mid_rel2_we", we_, 1'b1);
      chk("mid_rel2_addr", wr_addr, 5'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
